alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
Sequential issue stage directly upstream of the combinational ALU (operands a, b, 4-bit func, result out). It accepts operation requests over a valid/ready handshake and registers the operands and function onto the ALU inputs. After a programmable settle time it captures the ALU result into a small first-word-fall-through result FIFO. Downstream logic drains that FIFO through its own valid/ready handshake.

Parameters:
W, 2, operand/result width (equals ALU n+1)
FUNC_W, 4, ALU function code width
SETTLE, 1, cycles the ALU inputs are held before capture; legal range 1..15
DEPTH, 4, result FIFO entries; power of two, at least 2

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_a  in  W  operand a
req_b  in  W  operand b
req_func  in  FUNC_W  function code
alu_a  out  W  registered operand a to ALU
alu_b  out  W  registered operand b to ALU
alu_func  out  FUNC_W  registered function to ALU
alu_out  in  W  ALU combinational result
res_valid  out  1  FIFO head valid
res_ready  in  1  downstream consumes head
res_out  out  W  captured result at FIFO head
res_func  out  FUNC_W  function code that produced res_out
busy  out  1  high in WAIT state
op_count  out  8  completed captures, wrapping

Behaviour:
- One clock (clk). rst_n is asynchronous, active-low. Reset takes effect immediately on assertion; release is sampled on clk.
- Reset values: state IDLE; alu_a, alu_b, alu_func = 0; FIFO empty; res_valid = 0; res_out, res_func = 0; busy = 0; op_count = 0; settle counter = 0.
- States: IDLE, WAIT.
- req_ready = (state == IDLE) && (fifo_count < DEPTH). This is combinational from registered state only. It never depends on req_valid.
- IDLE:
  - On an edge with req_valid && req_ready, latch req_a/req_b/req_func into alu_a/alu_b/alu_func.
  - Load the settle counter with SETTLE and go to WAIT.
  - While req_ready = 0, req_* are ignored.
- WAIT:
  - busy = 1. The counter decrements each edge.
  - On the edge where the counter equals 1, push {alu_func, alu_out} into the FIFO, increment op_count, and return to IDLE.
  - Latency: a request accepted at edge k is captured at edge k+SETTLE and is visible on res_* after that edge if the FIFO was empty.
  - Throughput: one op per SETTLE+1 cycles.
- alu_a/alu_b/alu_func hold their value after capture until the next accept. They never change during WAIT.
- FIFO overflow is impossible. Accept requires count < DEPTH and only one op is in flight. The implementation still asserts (sim-only) that no push occurs at count == DEPTH.
- FIFO rules:
  - res_valid = (count != 0). res_out/res_func show the head combinationally from FIFO storage.
  - Pop on res_valid && res_ready. res_ready while empty is ignored.
  - Push with pop at count = 1: count stays 1 and the head becomes the new entry on the next cycle.
  - Push into empty: res_valid rises the cycle after the push edge, with no same-cycle bypass.
  - Pointers wrap modulo DEPTH.
- res_out/res_func hold the last head value when the FIFO is empty. The bench must not check them while res_valid = 0.
- op_count wraps from 255 to 0 with no saturation.
- Reset asserted mid-WAIT abandons the op: no push, and all state returns to reset values.

Test Plan:
- Bench ALU stub computes alu_out = alu_a ^ alu_b.
- Basic op, SETTLE=1, res_ready=1: req a=2'b11, b=2'b00, func=1 accepted at edge k -> alu_a=11, alu_b=00, alu_func=1 after k; busy high for 1 cycle; res_valid rises after edge k+1 with res_out=2'b11, res_func=1; op_count=1; req_ready low for exactly 1 cycle.
- Back-to-back ops, SETTLE=3: requests (10,11,func 0) then (01,01,func 7) with req_valid held high -> second accept occurs exactly 4 cycles after the first; results 2'b01/func 0 then 2'b00/func 7 appear in order.
- FIFO fill, DEPTH=4, res_ready=0: issue 5 requests -> 4 captured; req_ready stays low after the 4th push with the 5th request pending. Raise res_ready for one cycle -> one pop; 5th request is accepted on the next edge; order preserved.
- Simultaneous push and pop at count=1 -> count remains 1; head switches to the new result next cycle; no entry lost or duplicated.
- Reset mid-op: assert rst_n=0 during WAIT with SETTLE=5 -> all outputs are at reset values immediately (asynchronously). After release, res_valid=0 and op_count=0.
- Wrap: 256 completed ops -> op_count returns to 0. FIFO pointers wrap at least twice with correct data order.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Issue stage in front of a combinational ALU. It accepts a request over a
//   valid/ready handshake and registers the operands and function onto the
//   ALU inputs. It holds them for SETTLE cycles, then captures the ALU result
//   into a first-word-fall-through result FIFO that is drained downstream.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_a, req_b, req_func      request operands and function code
//   alu_a, alu_b, alu_func      registered ALU inputs, held until the next accept
//   alu_out                     combinational ALU result
//   res_valid/res_ready         result handshake (FIFO head)
//   res_out, res_func           FIFO head: result and the function that produced it
//   busy                        high while an op is settling
//   op_count                    completed captures, wraps at 256
//
// state | meaning
// IDLE  | waiting for a request; accepts when the FIFO has room
// WAIT  | ALU inputs held; settle counter runs down, capture on count==1
module alu_operand_sequencer #(
    parameter int W      = 2,
    parameter int FUNC_W = 4,
    parameter int SETTLE = 1,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W-1:0]      req_a,
    input  logic [W-1:0]      req_b,
    input  logic [FUNC_W-1:0] req_func,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [W-1:0]      alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_out,
    output logic [FUNC_W-1:0] res_func,
    output logic              busy,
    output logic [7:0]        op_count
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_nxt;
    logic [3:0]        settle_cnt, settle_cnt_nxt;
    logic              accept, capture, pop;

    logic [W-1:0]      res_mem  [DEPTH];
    logic [FUNC_W-1:0] func_mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       fifo_count;

    assign req_ready = (state == IDLE) && (fifo_count < (PW+1)'(DEPTH));
    assign busy      = (state == WAIT);
    assign res_valid = (fifo_count != '0);
    assign res_out   = res_mem[rd_ptr];
    assign res_func  = func_mem[rd_ptr];
    assign pop       = res_valid && res_ready;

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        accept         = 1'b0;
        capture        = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept         = 1'b1;
                    settle_cnt_nxt = 4'(SETTLE);
                    state_nxt      = WAIT;
                end
            end
            WAIT: begin
                settle_cnt_nxt = settle_cnt - 4'd1;
                if (settle_cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_func   <= '0;
            op_count   <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            if (accept) begin
                alu_a    <= req_a;
                alu_b    <= req_b;
                alu_func <= req_func;
            end
            if (capture)
                op_count <= op_count + 8'd1;
        end
    end

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                res_mem[i]  <= '0;
                func_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) begin
                res_mem[wr_ptr]  <= alu_out;
                func_mem[wr_ptr] <= alu_func;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Accept is gated on FIFO room with one op in flight, so a push into a full FIFO is a design bug.
    always @(posedge clk) begin
        if (rst_n && capture)
            assert (fifo_count != (PW+1)'(DEPTH));
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;
    localparam int W      = 2;
    localparam int FUNC_W = 4;
    localparam int SETTLE = 3;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready;
    logic [W-1:0]      req_a, req_b;
    logic [FUNC_W-1:0] req_func;
    logic [W-1:0]      alu_a, alu_b, alu_out;
    logic [FUNC_W-1:0] alu_func;
    logic              res_valid, res_ready;
    logic [W-1:0]      res_out;
    logic [FUNC_W-1:0] res_func;
    logic              busy;
    logic [7:0]        op_count;

    alu_operand_sequencer #(.W(W), .FUNC_W(FUNC_W), .SETTLE(SETTLE), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_func(req_func),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out(res_out), .res_func(res_func),
        .busy(busy), .op_count(op_count)
    );

    // ALU stub
    assign alu_out = alu_a ^ alu_b;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of {func, result}, one op in flight with a remaining-cycle count.
    logic [FUNC_W+W-1:0] mq[$];
    bit                  m_busy;
    int                  m_rem;
    logic [W-1:0]        m_a, m_b;
    logic [FUNC_W-1:0]   m_f;
    int                  m_ops;

    bit   last_acc;
    int   cyc;
    int   wraps;
    logic [7:0] prev_opc;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_rem = 0;
        m_a = '0; m_b = '0; m_f = '0;
        m_ops = 0;
    endtask

    task automatic check_all();
        check("req_ready", int'(req_ready), int'(!m_busy && mq.size() < DEPTH));
        check("busy", int'(busy), int'(m_busy));
        check("res_valid", int'(res_valid), int'(mq.size() != 0));
        check("alu_a", int'(alu_a), int'(m_a));
        check("alu_b", int'(alu_b), int'(m_b));
        check("alu_func", int'(alu_func), int'(m_f));
        check("op_count", int'(op_count), m_ops % 256);
        if (mq.size() != 0) begin
            check("res_out", int'(res_out), int'(mq[0][W-1:0]));
            check("res_func", int'(res_func), int'(mq[0][FUNC_W+W-1:W]));
        end
    endtask

    task automatic step();
        bit pop_m, acc_m;
        pop_m    = (mq.size() != 0) && res_ready;
        acc_m    = !m_busy && (mq.size() < DEPTH) && req_valid;
        last_acc = req_valid && req_ready;
        @(posedge clk);
        cyc++;
        if (pop_m) void'(mq.pop_front());
        if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                mq.push_back({m_f, m_a ^ m_b});
                m_ops++;
                m_busy = 0;
            end
        end else if (acc_m) begin
            m_a = req_a; m_b = req_b; m_f = req_func;
            m_busy = 1; m_rem = SETTLE;
        end
        #1;
        check_all();
        if (prev_opc == 8'd255 && op_count == 8'd0) wraps++;
        prev_opc = op_count;
    endtask

    // Hold the current request until accepted; flags a timeout.
    task automatic wait_accept(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) check({name, "_accept_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!res_valid && n < 40) begin
            step();
            n++;
        end
        if (!res_valid) check({name, "_valid_timeout"}, 0, 1);
    endtask

    typedef struct {
        logic [W-1:0]      a;
        logic [W-1:0]      b;
        logic [FUNC_W-1:0] f;
        logic [W-1:0]      exp_out;
    } vec_t;
    vec_t vt[6];

    initial begin
        int n, t0;
        vt[0] = '{a: 2'b11, b: 2'b00, f: 4'd1,  exp_out: 2'b11};
        vt[1] = '{a: 2'b10, b: 2'b11, f: 4'd0,  exp_out: 2'b01};
        vt[2] = '{a: 2'b01, b: 2'b01, f: 4'd7,  exp_out: 2'b00};
        vt[3] = '{a: 2'b00, b: 2'b10, f: 4'd15, exp_out: 2'b10};
        vt[4] = '{a: 2'b11, b: 2'b11, f: 4'd9,  exp_out: 2'b00};
        vt[5] = '{a: 2'b01, b: 2'b10, f: 4'd4,  exp_out: 2'b11};

        cyc = 0; wraps = 0; prev_opc = 8'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_func = '0; res_ready = 1'b0;
        model_reset();
        #12;
        check_all();
        check("reset_res_out", int'(res_out), 0);
        check("reset_res_func", int'(res_func), 0);
        rst_n = 1'b1;
        step();

        // Table: single ops with latency and result check
        foreach (vt[i]) begin
            req_a = vt[i].a; req_b = vt[i].b; req_func = vt[i].f; req_valid = 1'b1;
            wait_accept("tbl");
            req_valid = 1'b0;
            wait_valid("tbl", n);
            check("tbl_latency", n, SETTLE);
            check("tbl_out", int'(res_out), int'(vt[i].exp_out));
            check("tbl_func", int'(res_func), int'(vt[i].f));
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
        end

        // Back-to-back with req_valid held: accepts SETTLE+1 cycles apart
        req_a = 2'b10; req_b = 2'b11; req_func = 4'd0; req_valid = 1'b1;
        wait_accept("b2b1");
        t0 = cyc;
        req_a = 2'b01; req_b = 2'b01; req_func = 4'd7;
        wait_accept("b2b2");
        check("b2b_spacing", cyc - t0, SETTLE + 1);
        req_valid = 1'b0;
        for (int i = 0; i < SETTLE + 1; i++) step();
        check("b2b_first_out", int'(res_out), 1);
        check("b2b_first_func", int'(res_func), 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("b2b_second_out", int'(res_out), 0);
        check("b2b_second_func", int'(res_func), 7);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Fill: 4 captured, 5th pending until one pop
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_a = W'($urandom); req_b = W'($urandom); req_func = FUNC_W'($urandom);
            wait_accept("fill");
        end
        req_a = 2'b10; req_b = 2'b00; req_func = 4'd12;
        for (int i = 0; i < 3 * SETTLE; i++) step();
        check("fill_ready_low", int'(req_ready), 0);
        check("fill_valid", int'(res_valid), 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        step();
        check("fill_accept_after_pop", int'(last_acc), 1);
        req_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        res_ready = 1'b0;

        // Simultaneous push and pop at count==1
        req_a = 2'b01; req_b = 2'b00; req_func = 4'd2; req_valid = 1'b1;
        wait_accept("pp1");
        req_valid = 1'b0;
        wait_valid("pp1", n);
        req_a = 2'b10; req_b = 2'b01; req_func = 4'd5; req_valid = 1'b1;
        wait_accept("pp2");
        req_valid = 1'b0;
        for (int i = 0; i < SETTLE - 1; i++) step();
        check("pp_old_head", int'(res_out), 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("pp_valid", int'(res_valid), 1);
        check("pp_new_head", int'(res_out), 3);
        check("pp_new_func", int'(res_func), 5);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("pp_empty", int'(res_valid), 0);

        // Random traffic until op_count wraps
        n = 0;
        while (m_ops < 300 && n < 6000) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_a = W'($urandom); req_b = W'($urandom); req_func = FUNC_W'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        check("op_count_wrapped", int'(wraps >= 1), 1);

        // Reset during WAIT
        req_valid = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        res_ready = 1'b0;
        req_a = 2'b11; req_b = 2'b01; req_func = 4'd6; req_valid = 1'b1;
        wait_accept("rst");
        req_valid = 1'b0;
        step();
        check("rst_busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_res_out", int'(res_out), 0);
        check("rst_res_func", int'(res_func), 0);
        rst_n = 1'b1;
        prev_opc = 8'd0;
        for (int i = 0; i < SETTLE + 2; i++) step();
        check("rst_no_push", int'(res_valid), 0);
        check("rst_op_count", int'(op_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
